// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu with
// HI/LO result registers, mthi/mtlo writes and a busy flag for the hazard unit.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  iop,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iflush,
  input  logic        iRdLo,
  output logic        oBusy,
  output logic [31:0] oMDout,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  // 64-bit product; the signed case sign-extends both operands so the low
  // 64 bits of the 64x64 product equal the exact signed 32x32 product.
  function automatic logic [63:0] mul_result(input op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == OP_MULT) mul_result = 64'(sa * sb);
    else               mul_result = ua * ub;
  endfunction

  // Returns {remainder, quotient}. The single signed overflow case is pinned
  // explicitly rather than left to the language's division semantics.
  function automatic logic [63:0] div_result(input op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        div_result = {32'd0, 32'h8000_0000};
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        div_result = {sr, sq};
      end
    end else begin
      div_result = {a % b, a / b};
    end
  endfunction

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] cnt;
  op_e              op_p0;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;

  op_e              eop;
  logic             start;
  logic             start_req;
  logic [63:0]      mul_res;
  logic [63:0]      div_res;
  logic             div_zero;
  logic             is_mul_p0;

  always_comb begin
    eop = OP_NONE;
    if (!iflush && cnt == '0) begin
      case (iop)
        3'd1:    eop = OP_MULT;
        3'd2:    eop = OP_MULTU;
        3'd3:    eop = OP_DIV;
        3'd4:    eop = OP_DIVU;
        3'd5:    eop = OP_MTHI;
        3'd6:    eop = OP_MTLO;
        default: eop = OP_NONE;
      endcase
    end
  end

  assign start     = (eop == OP_MULT) || (eop == OP_MULTU) || (eop == OP_DIV) || (eop == OP_DIVU);
  assign start_req = (iop >= 3'd1) && (iop <= 3'd4) && !iflush;

  // Operand latch: pure data, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (start) begin
      a_p0 <= iA;
      b_p0 <= iB;
    end
  end

  // Commit stage: results evaluated from the latched operands.
  assign is_mul_p0 = (op_p0 == OP_MULT) || (op_p0 == OP_MULTU);
  assign mul_res   = mul_result(op_p0, a_p0, b_p0);
  assign div_res   = div_result(op_p0, a_p0, b_p0);
  assign div_zero  = (b_p0 == 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= '0;
      op_p0 <= OP_NONE;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        op_p0 <= OP_NONE;
        if (is_mul_p0) begin
          hi <= mul_res[63:32];
          lo <= mul_res[31:0];
        end else if (!div_zero) begin
          hi <= div_res[63:32];
          lo <= div_res[31:0];
        end
      end
    end else begin
      case (eop)
        OP_MULT, OP_MULTU: begin
          op_p0 <= eop;
          cnt   <= MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          op_p0 <= eop;
          cnt   <= DIV_LOAD;
        end
        OP_MTHI: hi <= iA;
        OP_MTLO: lo <= iA;
        default: ;
      endcase
    end
  end

  assign oBusy  = reset_n && (start_req || cnt != '0);
  assign oHI    = hi;
  assign oLO    = lo;
  assign oMDout = iRdLo ? lo : hi;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the P7 pipelined MIPS core. It sits in the E stage beside the ALU and executes mult/multu/div/divu over a fixed number of cycles, then holds the HI/LO results. It also services mthi/mtlo/mfhi/mflo. It drives the busy signal that the hazard unit consumes as its MD-busy stall input, and supplies the HI/LO read value forwarded as the MD result.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles the unit stays busy after a mult/multu start edge (≥1)
- DIV_CYCLES, 10, cycles the unit stays busy after a div/divu start edge (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; one clock, no other reset
- iop  in  3  E-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- iA  in  32  rs operand (already forwarded)
- iB  in  32  rt operand (already forwarded)
- iflush  in  1  exception/eret flush of the E-stage instruction; cancels this cycle's iop
- iRdLo  in  1  read select for oMDout: 0 HI, 1 LO
- oBusy  out  1  MD unit occupied; to hazard unit stall input
- oMDout  out  32  iRdLo ? LO : HI (combinational from registers)
- oHI  out  32  HI register
- oLO  out  32  LO register

## Operation
- State: HI[31:0], LO[31:0], cnt (wide enough for max(MULT_CYCLES, DIV_CYCLES)), latched operands, latched op.
- Effective op: eop = (iflush || cnt≠0) ? none : iop.
- Start (eop ∈ 1..4): at the clock edge, latch iA, iB, op; load cnt ← MULT_CYCLES or DIV_CYCLES.
- Countdown: when cnt≠0, cnt decrements each edge. On the edge where cnt==1, commit the result to HI/LO; cnt becomes 0.
- Result rules:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - Divide by zero (div or divu, iB==0): HI and LO are left unchanged; busy timing is still the full DIV_CYCLES.
- mthi/mtlo (eop 5/6): HI ← iA or LO ← iA at the edge, with no busy cycle.
- iop arriving while cnt≠0 (start, mthi, mtlo) is ignored. The hazard unit never issues this; it is defined only for robustness.
- iflush only cancels the same-cycle iop. An operation already in flight always completes and commits.
- oBusy = reset_n && ((iop ∈ 1..4 && !iflush) || cnt≠0). The start term makes an MD instruction in D stall during the start cycle.
- Reset (asynchronous, any time, including mid-operation): HI=0, LO=0, cnt=0, latched op=none. While reset_n=0: oBusy=0, oHI=oLO=oMDout=0. An in-flight result is discarded.

## Timing
- Start in cycle t: oBusy=1 in cycles t through t+N (N = MULT_CYCLES or DIV_CYCLES), i.e. N+1 cycles total.
- The new HI/LO values are visible on oHI/oLO/oMDout from cycle t+N+1, when oBusy=0.
- An mfhi/mflo held in D by the stall reads the correct value in its first unstalled E cycle.
- mthi/mtlo in cycle t: value visible from cycle t+1. A back-to-back mfhi in cycle t+1 is served with no stall.
- Back-to-back starts: the second start is accepted at the first cycle with cnt==0, i.e. at t+N+1.
- Deassertion of reset_n is recognised at the next rising edge. A start presented in that same cycle is accepted.

## Test plan
- Signed mult: reset; iop=1, iA=0xFFFFFFFE (−2), iB=3 in cycle 0 → oBusy high cycles 0–5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, oBusy=0.
- Unsigned vs signed divide:
  - divu, iA=0xFFFFFFF9, iB=2 → after 11 busy cycles: LO=0x7FFFFFFC, HI=1.
  - div, iA=−7, iB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Corner divides:
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - div by zero after mthi 0x1234 / mtlo 0x5678 → HI/LO unchanged after busy ends.
- Flush and ignore:
  - iop=1 with iflush=1 → oBusy low that cycle and after; HI/LO unchanged.
  - mtlo presented mid-divide → ignored; final LO is the quotient.
- mthi/mtlo/read: mthi 0xAAAA5555 then mtlo 0x0F0F0F0F on consecutive cycles → oBusy never high. Next cycle: oMDout=0xAAAA5555 with iRdLo=0, 0x0F0F0F0F with iRdLo=1.
- Async reset mid-op: start mult, pulse reset_n low between edges at cycle 3 → oBusy, HI, LO drop to 0 immediately; no commit afterwards. A mult started right after release completes normally.
